cnu_ib_load_ctrl: RTL and testbench
===================================

CNU_IB_LOAD_CTRL -- requirements
Module: cnu_ib_load_ctrl

Interface
REQ-001 SHALL have parameter ROM_AW, default 8, ROM address width (matches IB ROM address width).
REQ-002 SHALL have parameter PAIRS, default 16, ROM address pairs read per table load.
REQ-003 SHALL have parameter ITER_NUM, default 10, number of decoding-iteration tables stored in ROM.
REQ-004 SHALL have port sys_clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_i  in  1  request to load one iteration table.
REQ-007 SHALL have port iter_i  in  4  iteration index of table to load, sampled with start_i.
REQ-008 SHALL have port abort_i  in  1  cancel load in progress.
REQ-009 SHALL have port rom_en_o  out  1  ROM read enable.
REQ-010 SHALL have ports rom_addrA_o and rom_addrB_o  out  ROM_AW  ROM read addresses.
REQ-011 SHALL have port phase_o  out  1  ROM-data half-period select for the bank mapper (0 = first, 1 = second).
REQ-012 SHALL have port bank_rot_o  out  3  bank rotation offset for the mapper.
REQ-013 SHALL have port bank_we_o  out  8  per-bank write enable.
REQ-014 SHALL have ports busy_o, done_o, err_o  out  1 each  status; done_o and err_o are one-cycle pulses.

Function
REQ-015 SHALL implement states IDLE, LOAD, DRAIN, DONE; busy_o = 1 in LOAD and DRAIN.
REQ-016 SHALL accept start_i only in IDLE; start_i in any other state SHALL be ignored.
REQ-017 SHALL, if start_i accepted with iter_i >= ITER_NUM, stay IDLE and pulse err_o next cycle.
REQ-018 SHALL, on valid start, enter LOAD next cycle with rom_en_o = 1, rom_addrA_o = iter_i*2*PAIRS, rom_addrB_o = rom_addrA_o + 1 (truncated to ROM_AW).
REQ-019 SHALL, each LOAD cycle, advance both addresses by 2 and increment a pair counter; after the PAIRS-th issued pair, go to DRAIN.
REQ-020 SHALL treat ROM read latency as 1 cycle: data-valid flag = rom_en_o delayed 1 cycle; bank_we_o nonzero only when data valid.
REQ-021 SHALL toggle phase_o on every data-valid cycle, starting at 0 for the first valid cycle of a load.
REQ-022 SHALL, with r = bank_rot_o, assert bank_we_o bits (r+0..r+4) mod 8 when phase_o = 0, and bits (r+3..r+7) mod 8 when phase_o = 1.
REQ-023 SHALL increment bank_rot_o (mod 8) after each phase_o = 1 valid cycle; bank_rot_o SHALL be 0 at the start of every load.
REQ-024 SHALL hold DRAIN for exactly 1 cycle (rom_en_o = 0, last data written), then go to DONE.
REQ-025 SHALL pulse done_o for the 1 DONE cycle, then return to IDLE; total start-to-done = PAIRS + 2 cycles.
REQ-026 SHALL, on abort_i in LOAD or DRAIN, go to IDLE next cycle, force rom_en_o = 0 and bank_we_o = 0, and not pulse done_o; abort_i SHALL have priority over the end-of-load transition.
REQ-027 SHALL ignore abort_i in IDLE and DONE.

Reset
REQ-028 SHALL, on rstn low, force state IDLE, rom_en_o = 0, both addresses 0, phase_o = 0, bank_rot_o = 0, bank_we_o = 0, busy_o = done_o = err_o = 0, pair counter 0.
REQ-029 SHALL, on reset assertion mid-load, stop immediately and produce no done_o after release.

Structure
REQ-030 SHALL place state encoding, BANKS = 8 and the per-phase bank-write mask constants in the shared IB package.
REQ-031 SHALL use one sub-module, cnu_ib_bank_we_gen (combinational rotate of the 8-bit phase mask by bank_rot_o).

Verification
REQ-032 SHALL test: start_i with iter_i = 2, PAIRS = 16 -> first addresses 64/65, last 94/95, done_o 18 cycles after start.
REQ-033 SHALL test: first valid cycle of a load -> phase_o = 0, bank_we_o = 8'h1F; next cycle -> phase_o = 1, bank_we_o = 8'hF8; then bank_rot_o = 1 and bank_we_o = 8'h3E.
REQ-034 SHALL test: iter_i = 10 with ITER_NUM = 10 -> err_o pulse, busy_o stays 0, rom_en_o stays 0.
REQ-035 SHALL test: abort_i in the 5th LOAD cycle -> IDLE next cycle, bank_we_o = 0, no done_o; new start then completes normally.
REQ-036 SHALL test: start_i held high during LOAD -> single load, single done_o; rstn low mid-LOAD -> all outputs at reset values.

Source files
------------

// File: rtl/cnu_ib_load_ctrl_pkg.sv
// Shared IB definitions: load-controller state encoding, bank count and
// the per-phase bank write masks used by the bank mapper.
package cnu_ib_load_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ib_state_e;

  localparam int BANKS = 8;

  // First half of the ROM word covers 5 banks starting at the rotation
  // offset; the second half covers 5 banks starting 3 above it.
  localparam logic [BANKS-1:0] WE_MASK_PH0 = 8'h1F;
  localparam logic [BANKS-1:0] WE_MASK_PH1 = 8'hF8;

  // Unrotated write mask for the given ROM-data half
  function automatic logic [BANKS-1:0] phase_mask(input logic phase);
    logic [BANKS-1:0] m;
    if (phase) begin
      m = WE_MASK_PH1;
    end else begin
      m = WE_MASK_PH0;
    end
    return m;
  endfunction

endpackage

// File: rtl/cnu_ib_load_ctrl_bank_we_gen.sv
// Bank write-enable generator: rotates the phase mask left by the bank
// rotation offset, so bank (rot + k) mod 8 receives mask bit k.
module cnu_ib_bank_we_gen
  import cnu_ib_load_ctrl_pkg::*;
(
  input  logic             phase_i,
  input  logic [2:0]       rot_i,
  input  logic             valid_i,
  output logic [BANKS-1:0] we_o
);

  logic [2*BANKS-1:0] dbl_s;

  // Rotate via a doubled mask; gate with data-valid
  always_comb begin
    dbl_s = {phase_mask(phase_i), phase_mask(phase_i)} << rot_i;
    if (valid_i) begin
      we_o = dbl_s[2*BANKS-1:BANKS];
    end else begin
      we_o = {BANKS{1'b0}};
    end
  end

endmodule

// File: rtl/cnu_ib_load_ctrl.sv
// IB table load controller: streams PAIRS address pairs of one iteration
// table out of the IB ROM and drives the bank mapper's phase, rotation
// and per-bank write enables for the data returning one cycle later.
module cnu_ib_load_ctrl
  import cnu_ib_load_ctrl_pkg::*;
#(
  parameter int ROM_AW   = 8,
  parameter int PAIRS    = 16,
  parameter int ITER_NUM = 10
) (
  input  logic              sys_clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic [3:0]        iter_i,
  input  logic              abort_i,
  output logic              rom_en_o,
  output logic [ROM_AW-1:0] rom_addrA_o,
  output logic [ROM_AW-1:0] rom_addrB_o,
  output logic              phase_o,
  output logic [2:0]        bank_rot_o,
  output logic [BANKS-1:0]  bank_we_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int CNT_W = $clog2(PAIRS + 1);

  ib_state_e         state_q, state_d;
  logic              rom_en_q, rom_en_d;
  logic [ROM_AW-1:0] addr_a_q, addr_a_d;
  logic [ROM_AW-1:0] addr_b_q, addr_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              phase_q, phase_d;
  logic [2:0]        rot_q, rot_d;
  logic [BANKS-1:0]  we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ROM_AW-1:0] base_s;
  logic [BANKS-1:0]  we_s;

  // Next-state and next-output computation for the load sequencer
  always_comb begin
    base_s   = ROM_AW'(32'(iter_i) * 32'(2 * PAIRS));
    state_d  = state_q;
    rom_en_d = rom_en_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    cnt_d    = cnt_q;
    valid_d  = rom_en_q;
    err_d    = 1'b0;
    // Each valid data cycle flips the half; a completed second half moves
    // the rotation on to the next bank.
    if (valid_q) begin
      phase_d = ~phase_q;
      if (phase_q) begin
        rot_d = rot_q + 3'd1;
      end else begin
        rot_d = rot_q;
      end
    end else begin
      phase_d = phase_q;
      rot_d   = rot_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (32'(iter_i) >= 32'(ITER_NUM)) begin
            err_d = 1'b1;
          end else begin
            state_d  = ST_LOAD;
            rom_en_d = 1'b1;
            addr_a_d = base_s;
            addr_b_d = base_s + ROM_AW'(1);
            cnt_d    = CNT_W'(1);
            phase_d  = 1'b0;
            rot_d    = 3'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort_i) begin
          state_d  = ST_IDLE;
          rom_en_d = 1'b0;
          valid_d  = 1'b0;
        end else if (cnt_q == CNT_W'(PAIRS)) begin
          state_d  = ST_DRAIN;
          rom_en_d = 1'b0;
        end else begin
          addr_a_d = addr_a_q + ROM_AW'(2);
          addr_b_d = addr_b_q + ROM_AW'(2);
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        rom_en_d = 1'b0;
        valid_d  = 1'b0;
      end
    endcase

    busy_d = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
    we_d   = we_s;
  end

  cnu_ib_bank_we_gen u_we_gen (
    .phase_i (phase_d),
    .rot_i   (rot_d),
    .valid_i (valid_d),
    .we_o    (we_s)
  );

  // State and registered outputs, cleared asynchronously by rstn
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      rom_en_q <= 1'b0;
      addr_a_q <= {ROM_AW{1'b0}};
      addr_b_q <= {ROM_AW{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      valid_q  <= 1'b0;
      phase_q  <= 1'b0;
      rot_q    <= 3'd0;
      we_q     <= {BANKS{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rom_en_q <= rom_en_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      phase_q  <= phase_d;
      rot_q    <= rot_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign rom_en_o    = rom_en_q;
  assign rom_addrA_o = addr_a_q;
  assign rom_addrB_o = addr_b_q;
  assign phase_o     = phase_q;
  assign bank_rot_o  = rot_q;
  assign bank_we_o   = we_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_cnu_ib_load_ctrl.sv
// Bench for cnu_ib_load_ctrl: directed vector table, hand sequences for
// abort and mid-load reset, then random traffic against a per-load model.
module tb_cnu_ib_load_ctrl;

  localparam int ROM_AW   = 8;
  localparam int PAIRS    = 16;
  localparam int ITER_NUM = 10;

  logic              sys_clk = 1'b0;
  logic              rstn    = 1'b0;
  logic              start_i = 1'b0;
  logic [3:0]        iter_i  = 4'd0;
  logic              abort_i = 1'b0;
  logic              rom_en_o;
  logic [ROM_AW-1:0] rom_addrA_o;
  logic [ROM_AW-1:0] rom_addrB_o;
  logic              phase_o;
  logic [2:0]        bank_rot_o;
  logic [7:0]        bank_we_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  cnu_ib_load_ctrl #(.ROM_AW(ROM_AW), .PAIRS(PAIRS), .ITER_NUM(ITER_NUM)) dut (
    .sys_clk     (sys_clk),
    .rstn        (rstn),
    .start_i     (start_i),
    .iter_i      (iter_i),
    .abort_i     (abort_i),
    .rom_en_o    (rom_en_o),
    .rom_addrA_o (rom_addrA_o),
    .rom_addrB_o (rom_addrB_o),
    .phase_o     (phase_o),
    .bank_rot_o  (bank_rot_o),
    .bank_we_o   (bank_we_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", nm, got, want, $time);
    end
  endtask

  // Bank write pattern straight from the rule: 5 consecutive banks starting
  // at rot (first half) or rot+3 (second half), modulo 8.
  function automatic logic [7:0] exp_we(input int ph, input int rot);
    logic [7:0] w;
    int first;
    w = 8'h00;
    first = (ph != 0) ? 3 : 0;
    for (int o = 0; o < 5; o++) w[(rot + first + o) % 8] = 1'b1;
    return w;
  endfunction

  // Model: a load is described by its iteration and the cycle index n
  // since acceptance (1..PAIRS+2); everything else follows by formula.
  bit m_act = 1'b0;
  int m_n   = 0;
  int m_k   = 0;
  bit m_err = 1'b0;

  task automatic check_model();
    bit en, busy, done, valid;
    int j, a;
    en    = m_act && (m_n >= 1) && (m_n <= PAIRS);
    busy  = m_act && (m_n <= PAIRS + 1);
    done  = m_act && (m_n == PAIRS + 2);
    valid = m_act && (m_n >= 2) && (m_n <= PAIRS + 1);
    j = m_n - 2;
    a = m_k * 2 * PAIRS + 2 * (m_n - 1);
    cmp("m.rom_en", rom_en_o, en);
    cmp("m.busy", busy_o, busy);
    cmp("m.done", done_o, done);
    cmp("m.err", err_o, m_err);
    if (en) begin
      cmp("m.addrA", rom_addrA_o, a % 256);
      cmp("m.addrB", rom_addrB_o, (a + 1) % 256);
    end
    if (valid) begin
      cmp("m.phase", phase_o, j % 2);
      cmp("m.rot", bank_rot_o, (j / 2) % 8);
      cmp("m.we", bank_we_o, exp_we(j % 2, (j / 2) % 8));
    end else begin
      cmp("m.we_idle", bank_we_o, 32'd0);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model over
  // the coming rising edge, then check at the next falling edge.
  task automatic mstep(input bit s, input logic [3:0] it, input bit ab);
    start_i = s;
    iter_i  = it;
    abort_i = ab;
    m_err = 1'b0;
    if (!m_act) begin
      if (s) begin
        if (int'(it) >= ITER_NUM) begin
          m_err = 1'b1;
        end else begin
          m_act = 1'b1;
          m_n   = 1;
          m_k   = int'(it);
        end
      end
    end else if (ab && (m_n <= PAIRS + 1)) begin
      m_act = 1'b0;
    end else if (m_n == PAIRS + 2) begin
      m_act = 1'b0;
    end else begin
      m_n++;
    end
    @(negedge sys_clk);
    check_model();
  endtask

  typedef struct {
    logic s; logic [3:0] it; logic ab;
    logic en; logic busy; logic done; logic err;
    logic ca; logic [7:0] a;
    logic cwe; logic [7:0] we;
    logic cpr; logic ph; logic [2:0] rot;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic [3:0] it, input logic ab,
                              input logic en, input logic busy, input logic done, input logic err,
                              input logic ca, input logic [7:0] a, input logic cwe, input logic [7:0] we,
                              input logic cpr, input logic ph, input logic [2:0] rot);
    vec_t v;
    v.s = s; v.it = it; v.ab = ab; v.en = en; v.busy = busy; v.done = done; v.err = err;
    v.ca = ca; v.a = a; v.cwe = cwe; v.we = we; v.cpr = cpr; v.ph = ph; v.rot = rot;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    // iter 2 load with start held high throughout: one load, one done
    tbl.push_back(mk(1, 4'd2, 0, 1, 1, 0, 0, 1, 8'd64, 1, 8'h00, 0, 0, 3'd0));
    tbl.push_back(mk(1, 4'd2, 0, 1, 1, 0, 0, 1, 8'd66, 1, 8'h1F, 1, 0, 3'd0));
    tbl.push_back(mk(1, 4'd2, 0, 1, 1, 0, 0, 1, 8'd68, 1, 8'hF8, 1, 1, 3'd0));
    tbl.push_back(mk(1, 4'd2, 0, 1, 1, 0, 0, 1, 8'd70, 1, 8'h3E, 1, 0, 3'd1));
    for (int i = 5; i <= 15; i++)
      tbl.push_back(mk(1, 4'd2, 0, 1, 1, 0, 0, 0, 8'd0, 0, 8'h00, 0, 0, 3'd0));
    tbl.push_back(mk(1, 4'd2, 0, 1, 1, 0, 0, 1, 8'd94, 1, 8'h8F, 1, 0, 3'd7));
    tbl.push_back(mk(1, 4'd2, 0, 0, 1, 0, 0, 0, 8'd0, 1, 8'h7C, 1, 1, 3'd7));
    tbl.push_back(mk(1, 4'd2, 0, 0, 0, 1, 0, 0, 8'd0, 1, 8'h00, 0, 0, 3'd0));
    tbl.push_back(mk(1, 4'd2, 0, 0, 0, 0, 0, 0, 8'd0, 1, 8'h00, 0, 0, 3'd0));
    // out-of-range iterations
    tbl.push_back(mk(1, 4'd10, 0, 0, 0, 0, 1, 0, 8'd0, 1, 8'h00, 0, 0, 3'd0));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 0, 0, 8'd0, 1, 8'h00, 0, 0, 3'd0));
    tbl.push_back(mk(1, 4'd15, 0, 0, 0, 0, 1, 0, 8'd0, 1, 8'h00, 0, 0, 3'd0));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 0, 0, 8'd0, 1, 8'h00, 0, 0, 3'd0));
    // iter 9: base 288 truncates to 32; abort during the 5th LOAD cycle
    tbl.push_back(mk(1, 4'd9, 0, 1, 1, 0, 0, 1, 8'd32, 1, 8'h00, 0, 0, 3'd0));
    tbl.push_back(mk(0, 4'd0, 0, 1, 1, 0, 0, 1, 8'd34, 1, 8'h1F, 1, 0, 3'd0));
    tbl.push_back(mk(0, 4'd0, 0, 1, 1, 0, 0, 1, 8'd36, 1, 8'hF8, 1, 1, 3'd0));
    tbl.push_back(mk(0, 4'd0, 0, 1, 1, 0, 0, 1, 8'd38, 1, 8'h3E, 1, 0, 3'd1));
    tbl.push_back(mk(0, 4'd0, 0, 1, 1, 0, 0, 1, 8'd40, 1, 8'hF1, 1, 1, 3'd1));
    tbl.push_back(mk(0, 4'd0, 1, 0, 0, 0, 0, 0, 8'd0, 1, 8'h00, 0, 0, 3'd0));
    tbl.push_back(mk(0, 4'd0, 1, 0, 0, 0, 0, 0, 8'd0, 1, 8'h00, 0, 0, 3'd0));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 0, 0, 8'd0, 1, 8'h00, 0, 0, 3'd0));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 0, 0, 8'd0, 1, 8'h00, 0, 0, 3'd0));

    // reset values
    repeat (2) @(negedge sys_clk);
    cmp("rst.rom_en", rom_en_o, 32'd0);
    cmp("rst.addrA", rom_addrA_o, 32'd0);
    cmp("rst.addrB", rom_addrB_o, 32'd0);
    cmp("rst.phase", phase_o, 32'd0);
    cmp("rst.rot", bank_rot_o, 32'd0);
    cmp("rst.we", bank_we_o, 32'd0);
    cmp("rst.busy", busy_o, 32'd0);
    cmp("rst.done", done_o, 32'd0);
    cmp("rst.err", err_o, 32'd0);
    rstn = 1'b1;

    // table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      start_i = tbl[i].s;
      iter_i  = tbl[i].it;
      abort_i = tbl[i].ab;
      @(negedge sys_clk);
      cmp($sformatf("tbl%0d.en", i), rom_en_o, tbl[i].en);
      cmp($sformatf("tbl%0d.busy", i), busy_o, tbl[i].busy);
      cmp($sformatf("tbl%0d.done", i), done_o, tbl[i].done);
      cmp($sformatf("tbl%0d.err", i), err_o, tbl[i].err);
      if (tbl[i].ca) begin
        cmp($sformatf("tbl%0d.addrA", i), rom_addrA_o, tbl[i].a);
        cmp($sformatf("tbl%0d.addrB", i), rom_addrB_o, tbl[i].a + 8'd1);
      end
      if (tbl[i].cwe) cmp($sformatf("tbl%0d.we", i), bank_we_o, tbl[i].we);
      if (tbl[i].cpr) begin
        cmp($sformatf("tbl%0d.phase", i), phase_o, tbl[i].ph);
        cmp($sformatf("tbl%0d.rot", i), bank_rot_o, tbl[i].rot);
      end
    end

    // a fresh start after the abort runs to completion
    mstep(1'b1, 4'd4, 1'b0);
    repeat (PAIRS + 3) mstep(1'b0, 4'd0, 1'b0);

    // reset asserted mid-load: outputs clear at once, no done afterwards
    mstep(1'b1, 4'd5, 1'b0);
    repeat (4) mstep(1'b0, 4'd0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    cmp("mid.rom_en", rom_en_o, 32'd0);
    cmp("mid.addrA", rom_addrA_o, 32'd0);
    cmp("mid.addrB", rom_addrB_o, 32'd0);
    cmp("mid.phase", phase_o, 32'd0);
    cmp("mid.rot", bank_rot_o, 32'd0);
    cmp("mid.we", bank_we_o, 32'd0);
    cmp("mid.busy", busy_o, 32'd0);
    cmp("mid.done", done_o, 32'd0);
    cmp("mid.err", err_o, 32'd0);
    @(negedge sys_clk);
    rstn  = 1'b1;
    m_act = 1'b0;
    m_err = 1'b0;
    repeat (PAIRS + 4) mstep(1'b0, 4'd0, 1'b0);

    // random traffic: starts (some out of range, some while busy) and aborts
    for (int c = 0; c < 2000; c++) begin
      mstep(($urandom % 4) == 0, 4'($urandom % 12), ($urandom % 25) == 0);
    end
    repeat (PAIRS + 4) mstep(1'b0, 4'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
